// File: rtl/axis_frame_gen.sv
// AXI-Stream frame generator: programmable-length frames of an incrementing byte pattern.
// Define AXIS_FRAME_GEN_THROTTLE_EN to insert pseudo-random tvalid bubbles between beats.
module axis_frame_gen #(
   parameter int DATA_WIDTH = 8,
   parameter int LEN_WIDTH  = 16,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                    s_aclk,
   input  logic                    s_sresetn,
   input  logic                    start,
   input  logic                    stop,
   input  logic [LEN_WIDTH-1:0]    frame_len,
   input  logic [7:0]              ifg,
   input  logic [CNT_WIDTH-1:0]    num_frames,
   input  logic                    err_inject,
   output logic [DATA_WIDTH-1:0]   m_axis_tdata,
   output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
   output logic                    m_axis_tvalid,
   output logic                    m_axis_tlast,
   output logic                    m_axis_tuser,
   input  logic                    m_axis_trdy,
   output logic                    busy,
   output logic                    done,
   output logic [CNT_WIDTH-1:0]    frames_sent
);

   localparam int KEEP_W = DATA_WIDTH / 8;
   localparam logic [LEN_WIDTH-1:0] KEEP_LEN = LEN_WIDTH'(KEEP_W);
   localparam logic [CNT_WIDTH-1:0] ONE_CNT  = CNT_WIDTH'(1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_DATA = 2'd1;
   localparam logic [1:0] ST_GAP  = 2'd2;

   logic [1:0]            r_state;
   logic [LEN_WIDTH-1:0]  r_len;
   logic [LEN_WIDTH-1:0]  r_off;
   logic [7:0]            r_ifg;
   logic [7:0]            r_gapCnt;
   logic [CNT_WIDTH-1:0]  r_num;
   logic [CNT_WIDTH-1:0]  r_runCnt;
   logic [CNT_WIDTH-1:0]  r_sent;
   logic                  r_err;
   logic                  r_stop;
   logic                  r_done;

   logic                  w_bubble;
   logic                  w_valid;
   logic                  w_hs;
   logic                  w_last;
   logic                  w_stopNow;
   logic                  w_runEnd;
   logic [LEN_WIDTH-1:0]  w_remain;
   logic [DATA_WIDTH-1:0] w_data;
   logic [KEEP_W-1:0]     w_keep;

   assign w_valid   = (r_state == ST_DATA) && !w_bubble;
   assign w_hs      = w_valid && m_axis_trdy;
   assign w_remain  = r_len - r_off;
   assign w_last    = ({1'b0, w_remain} <= {1'b0, KEEP_LEN});
   assign w_stopNow = stop || r_stop;
   assign w_runEnd  = w_stopNow || ((r_num != '0) && ((r_runCnt + ONE_CNT) == r_num));

   // The frame base byte is frames_sent itself: it only moves on a last-beat handshake.
   always_comb begin
      w_data = '0;
      w_keep = '0;
      for (int i = 0; i < KEEP_W; i++) begin
         if (LEN_WIDTH'(i) < w_remain) begin
            w_keep[i]          = 1'b1;
            w_data[i*8 +: 8]   = r_sent[7:0] + r_off[7:0] + 8'(i);
         end
      end
   end

`ifdef AXIS_FRAME_GEN_THROTTLE_EN
   logic [15:0] r_lfsr;
   logic        r_bubble;

   always_ff @(posedge s_aclk) begin
      if (!s_sresetn) begin
         r_lfsr   <= 16'hACE1;
         r_bubble <= 1'b0;
      end else begin
         r_lfsr   <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
         r_bubble <= w_hs && !w_last && (r_lfsr[1:0] == 2'b00);
      end
   end

   assign w_bubble = r_bubble;
`else
   assign w_bubble = 1'b0;
`endif

   always_ff @(posedge s_aclk) begin
      if (!s_sresetn) begin
         r_state  <= ST_IDLE;
         r_len    <= '0;
         r_off    <= '0;
         r_ifg    <= '0;
         r_gapCnt <= '0;
         r_num    <= '0;
         r_runCnt <= '0;
         r_sent   <= '0;
         r_err    <= 1'b0;
         r_stop   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start && (frame_len != '0)) begin
                  r_len    <= frame_len;
                  r_ifg    <= ifg;
                  r_num    <= num_frames;
                  r_err    <= err_inject;
                  r_off    <= '0;
                  r_runCnt <= '0;
                  r_stop   <= 1'b0;
                  r_state  <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (stop) r_stop <= 1'b1;
               if (w_hs) begin
                  if (w_last) begin
                     r_sent   <= r_sent + ONE_CNT;
                     r_runCnt <= r_runCnt + ONE_CNT;
                     r_off    <= '0;
                     if (w_runEnd) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                     end else if (r_ifg != 8'd0) begin
                        r_state  <= ST_GAP;
                        r_gapCnt <= r_ifg;
                     end
                  end else begin
                     r_off <= r_off + KEEP_LEN;
                  end
               end
            end
            ST_GAP: begin
               // Stop is only ever pending here as a live input; a sticky stop already ended the run.
               if (w_stopNow) begin
                  r_state <= ST_IDLE;
                  r_done  <= 1'b1;
               end else if (r_gapCnt == 8'd1) begin
                  r_state <= ST_DATA;
               end else begin
                  r_gapCnt <= r_gapCnt - 8'd1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign m_axis_tvalid = w_valid;
   assign m_axis_tdata  = w_valid ? w_data : '0;
   assign m_axis_tkeep  = w_valid ? w_keep : '0;
   assign m_axis_tlast  = w_valid && w_last;
   assign m_axis_tuser  = w_valid && w_last && r_err;
   assign busy          = (r_state != ST_IDLE);
   assign done          = r_done;
   assign frames_sent   = r_sent;

endmodule
